mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//   Iterative multiply/divide unit for the EX stage; sits beside the ALU and takes the
//   same op1/op2 operands and the same 6-bit funct encoding. It owns the HI/LO registers.
//   Executes mult/multu/div/divu over multiple cycles and mthi/mtlo in one cycle.
//   It also supplies mfhi/mflo read data to the writeback mux. busy stalls the pipeline.
// PARAMETERS
//   WIDTH    32    operand width; HI/LO width; iteration count = WIDTH
// PORTS
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous reset, active-low
//   start    in   1      issue strobe; opcode/op1/op2 valid this cycle
//   opcode   in   6      funct: 18 mult, 19 multu, 1A div, 1B divu, 10 mfhi, 11 mthi, 12 mflo, 13 mtlo
//   op1      in   WIDTH  rs value (multiplicand/dividend; mthi/mtlo source)
//   op2      in   WIDTH  rt value (multiplier/divisor)
//   flush    in   1      synchronous abort of an in-flight operation
//   busy     out  1      multi-cycle op in flight (state != IDLE)
//   done     out  1      one-cycle pulse: HI/LO just updated by mult/div
//   hi       out  WIDTH  HI register
//   lo       out  WIDTH  LO register
//   rd_data  out  WIDTH  combinational: opcode 10 -> hi, 12 -> lo, else 0
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE, hi=lo=0, busy=0, done=0, counter=0; wins over everything.
//   FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: at an edge with start=1 and flush=0:
//     - opcode 18/19/1A/1B: latch operand magnitudes (signed ops) or raw values (unsigned).
//       Latch the sign flags. Clear the accumulator. counter=0. Go to RUN.
//     - opcode 11: hi<=op1. Opcode 13: lo<=op1. Stay in IDLE. No done pulse.
//     - any other opcode: ignored.
//   RUN: one radix-2 step per edge; exactly WIDTH edges; the last step goes to FIX.
//     - mul: shift-add, 2*WIDTH-bit unsigned product of the magnitudes.
//     - div: restoring division of the magnitudes; quotient and remainder are WIDTH bits.
//   FIX (one edge): apply sign, write hi/lo, done<=1, go to IDLE.
//     - mult: negate the 64-bit product if the operand signs differ; hi=upper, lo=lower.
//     - div: quotient negated if the signs differ; remainder takes the dividend's sign.
//       lo=quotient, hi=remainder.
//   Latency: with start sampled at edge E0, busy=1 after E0 through E33.
//     hi/lo are updated and done=1 for exactly one cycle after E33 (33 edges).
//   done is 0 in every cycle except the one after FIX.
//   Divide by zero (op2=0, div or divu): full latency; hi=op1 (raw), lo=all-ones.
//   Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   Wrap-around: all arithmetic is modulo 2^WIDTH per half; no exceptions, no flags.
//   start while busy: ignored. The pipeline holds the instruction on busy; no queuing.
//   flush=1 at any edge: state->IDLE, counter=0, no done pulse, hi/lo keep their pre-op values.
//     flush with start in IDLE: flush wins; nothing is accepted, including mthi/mtlo.
//   flush in the FIX cycle: flush wins; hi/lo are not written.
//   mfhi/mflo while busy: rd_data shows the old hi/lo; the pipeline must stall on busy.
//   Reset mid-operation: abandons the op immediately; hi=lo=0.
// TESTING
//   multu FFFFFFFF*FFFFFFFF -> after 33 edges: hi=FFFFFFFE, lo=00000001, done pulses once.
//   mult FFFFFFFD(-3)*00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; busy high exactly 33 cycles.
//   div FFFFFFF9(-7)/00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     divu 7/0 -> hi=00000007, lo=FFFFFFFF.
//   div 80000000/FFFFFFFF -> lo=80000000, hi=0. mthi 1234 then mfhi -> rd_data=00001234.
//   mult in flight, flush at edge 10 -> busy=0 next cycle, no done, hi/lo unchanged.
//     start while busy is ignored.
//   rst_n low at edge 20 of divu -> hi=lo=0, busy=0 immediately (async).
//     A new multu 3*4 after release -> lo=0000000C.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the EX-stage issue logic and the multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    // Pipeline side: issues operations and reads HI/LO back.
    modport master (
        output start, opcode, op1, op2, flush,
        input  busy, done, hi, lo, rd_data
    );

    // Unit side: owns HI/LO and the iterative datapath.
    modport slave (
        input  start, opcode, op1, op2, flush,
        output busy, done, hi, lo, rd_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// mult/multu/div/divu take WIDTH iteration cycles plus one sign-fix cycle;
// mthi/mtlo complete in one cycle; mfhi/mflo are served combinationally.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    state_t               state_reg,   state_next;
    logic [CNT_W-1:0]     counter_reg, counter_next;
    // mul: {partial product high half, remaining multiplier bits}
    // div: {partial remainder, dividend bits shifting out / quotient bits shifting in}
    logic [2*WIDTH-1:0]   acc_reg,     acc_next;
    // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [WIDTH-1:0]     oper_reg,    oper_next;
    logic                 is_div_reg,  is_div_next;
    logic                 neg_res_reg, neg_res_next;  // operand signs differ
    logic                 neg_rem_reg, neg_rem_next;  // dividend was negative
    logic                 div0_reg,    div0_next;
    logic [WIDTH-1:0]     hi_reg,      hi_next;
    logic [WIDTH-1:0]     lo_reg,      lo_next;
    logic                 done_reg,    done_next;

    // Operand conditioning at issue time
    logic                 is_signed_op;
    logic                 sign1;
    logic                 sign2;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;

    assign is_signed_op = (bus.opcode == OP_MULT) || (bus.opcode == OP_DIV);
    assign sign1        = is_signed_op & bus.op1[WIDTH-1];
    assign sign2        = is_signed_op & bus.op2[WIDTH-1];
    assign mag1         = sign1 ? (-bus.op1) : bus.op1;
    assign mag2         = sign2 ? (-bus.op2) : bus.op2;

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right keeping the carry.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, oper_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor if it fits, record the quotient bit.
    // The shifted remainder is WIDTH+1 bits; after a successful subtract the
    // result is below the divisor, so a WIDTH-bit difference is exact.
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_step;

    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_fits  = (div_shift >= {1'b0, oper_reg});
    assign div_sub   = div_shift[WIDTH-1:0] - oper_reg;
    assign div_step  = div_fits ? {div_sub, acc_reg[WIDTH-2:0], 1'b1}
                                : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    // Sign correction applied in the FIX cycle
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign prod_fix = neg_res_reg ? (-acc_reg) : acc_reg;
    // Divide-by-zero forces an all-ones quotient; the remainder path already
    // reproduces the raw dividend because every subtract of zero succeeds.
    assign quo_fix  = div0_reg    ? {WIDTH{1'b1}}
                    : (neg_res_reg ? (-acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0]);
    assign rem_fix  = neg_rem_reg ? (-acc_reg[2*WIDTH-1:WIDTH]) : acc_reg[2*WIDTH-1:WIDTH];

    // Next-state and datapath update for IDLE -> RUN -> FIX -> IDLE
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        acc_next     = acc_reg;
        oper_next    = oper_reg;
        is_div_next  = is_div_reg;
        neg_res_next = neg_res_reg;
        neg_rem_next = neg_rem_reg;
        div0_next    = div0_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = 1'b0;

        if (bus.flush) begin
            // Abort wins over everything, including a same-cycle issue.
            state_next   = IDLE;
            counter_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.opcode)
                            OP_MULT, OP_MULTU: begin
                                state_next   = RUN;
                                counter_next = '0;
                                acc_next     = {{WIDTH{1'b0}}, mag2};
                                oper_next    = mag1;
                                is_div_next  = 1'b0;
                                neg_res_next = sign1 ^ sign2;
                                neg_rem_next = sign1;
                                div0_next    = 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_next   = RUN;
                                counter_next = '0;
                                acc_next     = {{WIDTH{1'b0}}, mag1};
                                oper_next    = mag2;
                                is_div_next  = 1'b1;
                                neg_res_next = sign1 ^ sign2;
                                neg_rem_next = sign1;
                                div0_next    = (bus.op2 == '0);
                            end
                            OP_MTHI: hi_next = bus.op1;
                            OP_MTLO: lo_next = bus.op1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_next     = is_div_reg ? div_step : mul_step;
                    counter_next = counter_reg + CNT_W'(1);
                    if (counter_reg == CNT_W'(WIDTH - 1)) begin
                        state_next   = FIX;
                        counter_next = '0;
                    end
                end
                FIX: begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    if (is_div_reg) begin
                        hi_next = rem_fix;
                        lo_next = quo_fix;
                    end else begin
                        hi_next = prod_fix[2*WIDTH-1:WIDTH];
                        lo_next = prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    state_next   = IDLE;
                    counter_next = '0;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any operation and clears HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            acc_reg     <= '0;
            oper_reg    <= '0;
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            div0_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            acc_reg     <= acc_next;
            oper_reg    <= oper_next;
            is_div_reg  <= is_div_next;
            neg_res_reg <= neg_res_next;
            neg_rem_reg <= neg_rem_next;
            div0_reg    <= div0_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
        end
    end

    // mfhi/mflo read port; shows the committed HI/LO even while busy
    always_comb begin
        bus.rd_data = '0;
        if (bus.opcode == OP_MFHI) begin
            bus.rd_data = hi_reg;
        end else if (bus.opcode == OP_MFLO) begin
            bus.rd_data = lo_reg;
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule
